// File: rtl/multi_channel_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : multi_channel_scoreboard
// Brief    : Passive per-channel magic-packet checker for NUM_CH FIFOs.
//            Optional re-arm from PASS when SB_REARM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module multi_channel_scoreboard #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       push,
    input  logic [NUM_CH-1:0]       pop,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH*WIDTH-1:0] flat_data_in,
    input  logic [NUM_CH*WIDTH-1:0] flat_data_out,
    output logic [NUM_CH-1:0]       tracking,
    output logic [NUM_CH-1:0]       chk_vld,
    output logic [NUM_CH-1:0]       chk_pass,
    output logic [NUM_CH-1:0]       proto_err,
    output logic                    prop_signal
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_TRACK = 3'd2,
        S_PASS  = 3'd3,
        S_FAIL  = 3'd4
    } state_t;

    localparam logic [CNTWID-1:0] c_DEPTH = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] c_ONE   = CNTWID'(1);

    logic [NUM_CH-1:0] w_fail;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            state_t            r_state;
            logic [CNTWID-1:0] r_occ;
            logic [CNTWID-1:0] r_trk;
            logic [WIDTH-1:0]  r_magic;
            logic              r_vld;
            logic              r_pass;
            logic              r_err;

            logic [WIDTH-1:0]  w_din;
            logic [WIDTH-1:0]  w_dout;
            logic              w_full;
            logic              w_empty;
            logic              w_push_ok;
            logic              w_pop_ok;
            logic              w_proto;
            logic              w_start_ok;
            logic              w_capture;
            logic              w_arm;

            assign w_din   = flat_data_in[gi*WIDTH +: WIDTH];
            assign w_dout  = flat_data_out[gi*WIDTH +: WIDTH];
            assign w_full  = (r_occ == c_DEPTH);
            assign w_empty = (r_occ == '0);

            // A push on a full FIFO is legal when a pop frees the slot in the same cycle.
            assign w_push_ok = push[gi] && (!w_full || pop[gi]);
            assign w_pop_ok  = pop[gi] && !w_empty;
            assign w_proto   = (push[gi] && w_full && !pop[gi]) || (pop[gi] && w_empty);

`ifdef SB_REARM_EN
            assign w_start_ok = start[gi] && ((r_state == S_IDLE) || (r_state == S_PASS));
`else
            assign w_start_ok = start[gi] && (r_state == S_IDLE);
`endif
            assign w_capture = w_push_ok && (w_start_ok || (r_state == S_ARMED));
            assign w_arm     = w_start_ok && !w_push_ok;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= S_IDLE;
                    r_occ   <= '0;
                    r_trk   <= '0;
                    r_magic <= '0;
                    r_vld   <= 1'b0;
                    r_pass  <= 1'b0;
                    r_err   <= 1'b0;
                end else begin
                    r_vld  <= 1'b0;
                    r_pass <= 1'b0;
                    if (w_proto) begin
                        r_err <= 1'b1;
                    end
                    case ({w_push_ok, w_pop_ok})
                        2'b10:   r_occ <= r_occ + c_ONE;
                        2'b01:   r_occ <= r_occ - c_ONE;
                        default: r_occ <= r_occ;
                    endcase
                    if (w_capture) begin
                        r_magic <= w_din;
                        r_trk   <= r_occ + c_ONE - {{(CNTWID-1){1'b0}}, w_pop_ok};
                        r_state <= S_TRACK;
                    end else if (w_arm) begin
                        r_state <= S_ARMED;
                    end else if ((r_state == S_TRACK) && w_pop_ok) begin
                        if (r_trk == c_ONE) begin
                            r_vld   <= 1'b1;
                            r_pass  <= (w_dout == r_magic);
                            r_state <= (w_dout == r_magic) ? S_PASS : S_FAIL;
                        end else begin
                            r_trk <= r_trk - c_ONE;
                        end
                    end
                end
            end

            assign tracking[gi]  = (r_state == S_ARMED) || (r_state == S_TRACK);
            assign chk_vld[gi]   = r_vld;
            assign chk_pass[gi]  = r_pass;
            assign proto_err[gi] = r_err;
            assign w_fail[gi]    = (r_state == S_FAIL);
        end
    endgenerate

    assign prop_signal = ~|w_fail;

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_channel_scoreboard
// Brief    : Table vectors, directed corner sequences and a queue-based
//            reference model driven by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_channel_scoreboard;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  push = '0, pop = '0, start = '0;
    logic [31:0] flat_data_in = '0, flat_data_out = '0;
    logic [3:0]  tracking, chk_vld, chk_pass, proto_err;
    logic        prop_signal;

    int total = 0;
    int bad   = 0;

    multi_channel_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .start        (start),
        .flat_data_in (flat_data_in),
        .flat_data_out(flat_data_out),
        .tracking     (tracking),
        .chk_vld      (chk_vld),
        .chk_pass     (chk_pass),
        .proto_err    (proto_err),
        .prop_signal  (prop_signal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  pu, po, st;
        logic [31:0] di, dq;
        logic [3:0]  vld, pass, err, trk;
        logic        prop;
    } vec_t;

    vec_t tv[9];

    // Reference model: each FIFO as an array of entries tagged with a magic flag.
    logic [7:0] mdat  [4][8];
    bit         mflag [4][8];
    int         mcnt  [4];
    int         mmode [4];   // 0 idle, 1 armed, 2 track, 3 pass, 4 fail
    logic [7:0] mmagic[4];
    logic [3:0] merr, exp_vld, exp_pass;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] pu, input logic [3:0] po, input logic [3:0] st,
                       input logic [31:0] di, input logic [31:0] dq);
        @(negedge clk);
        push = pu; pop = po; start = st; flat_data_in = di; flat_data_out = dq;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        push = '0; pop = '0; start = '0; flat_data_in = '0; flat_data_out = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            mcnt[c] = 0; mmode[c] = 0; mmagic[c] = '0;
        end
        merr = '0;
    endtask

    task automatic model_step();
        exp_vld = '0; exp_pass = '0;
        for (int c = 0; c < 4; c++) begin
            logic [7:0] din, dq, head;
            bit p, o, s, pok, uok, hflag, startable, cap;
            p = push[c]; o = pop[c]; s = start[c];
            din = flat_data_in[c*8 +: 8];
            dq  = flat_data_out[c*8 +: 8];
            pok = o && (mcnt[c] > 0);
            uok = p && ((mcnt[c] < 8) || o);
            if ((p && mcnt[c] == 8 && !o) || (o && mcnt[c] == 0)) merr[c] = 1'b1;
`ifdef SB_REARM_EN
            startable = s && (mmode[c] == 0 || mmode[c] == 3);
`else
            startable = s && (mmode[c] == 0);
`endif
            cap = uok && (startable || mmode[c] == 1);
            if (pok) begin
                head = mdat[c][0]; hflag = mflag[c][0];
                for (int k = 0; k < 7; k++) begin
                    mdat[c][k] = mdat[c][k+1]; mflag[c][k] = mflag[c][k+1];
                end
                mcnt[c]--;
                if (hflag && mmode[c] == 2) begin
                    exp_vld[c]  = 1'b1;
                    exp_pass[c] = (dq == mmagic[c]);
                    mmode[c]    = exp_pass[c] ? 3 : 4;
                end
            end
            if (uok) begin
                mdat[c][mcnt[c]] = din; mflag[c][mcnt[c]] = cap; mcnt[c]++;
            end
            if (cap) begin
                mmagic[c] = din; mmode[c] = 2;
            end else if (startable) begin
                mmode[c] = 1;
            end
        end
    endtask

    function automatic logic [3:0] model_trk();
        logic [3:0] t;
        for (int c = 0; c < 4; c++) t[c] = (mmode[c] == 1 || mmode[c] == 2);
        return t;
    endfunction

    function automatic logic model_prop();
        logic pr = 1'b1;
        for (int c = 0; c < 4; c++) if (mmode[c] == 4) pr = 1'b0;
        return pr;
    endfunction

    initial begin
        //          push   pop    start  din           dout          vld    pass   err    trk    prop
        tv[0] = '{4'b0011, 4'b0000, 4'b0001, 32'h0000_015A, 32'h0, 4'b0000, 4'b0000, 4'b0, 4'b0001, 1'b1};
        tv[1] = '{4'b0010, 4'b0001, 4'b0000, 32'h0000_0200, 32'h0000_005A, 4'b0001, 4'b0001, 4'b0, 4'b0000, 1'b1};
        tv[2] = '{4'b0010, 4'b0000, 4'b0000, 32'h0000_0300, 32'h0, 4'b0000, 4'b0000, 4'b0, 4'b0000, 1'b1};
        tv[3] = '{4'b0110, 4'b0000, 4'b0110, 32'h0011_3300, 32'h0, 4'b0000, 4'b0000, 4'b0, 4'b0110, 1'b1};
        tv[4] = '{4'b0000, 4'b0110, 4'b0000, 32'h0, 32'h0012_0100, 4'b0100, 4'b0000, 4'b0, 4'b0010, 1'b0};
        tv[5] = '{4'b0000, 4'b0010, 4'b0000, 32'h0, 32'h0000_0200, 4'b0000, 4'b0000, 4'b0, 4'b0010, 1'b0};
        tv[6] = '{4'b0000, 4'b0010, 4'b0000, 32'h0, 32'h0000_0300, 4'b0000, 4'b0000, 4'b0, 4'b0010, 1'b0};
        tv[7] = '{4'b0000, 4'b0010, 4'b0000, 32'h0, 32'h0000_3300, 4'b0010, 4'b0010, 4'b0, 4'b0000, 1'b0};
        tv[8] = '{4'b0000, 4'b0000, 4'b0000, 32'h0, 32'h0, 4'b0000, 4'b0000, 4'b0, 4'b0000, 1'b0};

        #2;
        chk("rst_trk", tracking, 0);
        chk("rst_vld", chk_vld, 0);
        chk("rst_pass", chk_pass, 0);
        chk("rst_err", proto_err, 0);
        chk("rst_prop", prop_signal, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            cyc(tv[i].pu, tv[i].po, tv[i].st, tv[i].di, tv[i].dq);
            chk($sformatf("tv%0d_vld", i), chk_vld, tv[i].vld);
            chk($sformatf("tv%0d_pass", i), chk_pass, tv[i].pass);
            chk($sformatf("tv%0d_err", i), proto_err, tv[i].err);
            chk($sformatf("tv%0d_trk", i), tracking, tv[i].trk);
            chk($sformatf("tv%0d_prop", i), prop_signal, tv[i].prop);
        end

        // Overflow on ch3 must leave occupancy at DEPTH; underflow on ch0.
        do_reset();
        for (int i = 0; i < 8; i++) cyc(4'b1000, 4'b0, 4'b0, 32'h0100_0000 * i, 32'h0);
        chk("ovf_err_clean", proto_err, 4'b0000);
        cyc(4'b1000, 4'b0, 4'b0, 32'hEE00_0000, 32'h0);
        chk("ovf_err", proto_err, 4'b1000);
        cyc(4'b0000, 4'b0001, 4'b0, 32'h0, 32'h0);
        chk("udf_err", proto_err, 4'b1001);
        cyc(4'b1000, 4'b1000, 4'b1000, 32'hC300_0000, 32'h0);
        chk("full_cap_trk", tracking, 4'b1000);
        for (int i = 0; i < 7; i++) begin
            cyc(4'b0000, 4'b1000, 4'b0, 32'h0, 32'h0);
            chk($sformatf("full_wait%0d_vld", i), chk_vld, 4'b0000);
        end
        cyc(4'b0000, 4'b1000, 4'b0, 32'h0, 32'hC300_0000);
        chk("full_exit_vld", chk_vld, 4'b1000);
        chk("full_exit_pass", chk_pass, 4'b1000);

        // Simultaneous exits on ch0 and ch1.
        do_reset();
        cyc(4'b0011, 4'b0, 4'b0011, 32'h0000_A1B2, 32'h0);
        cyc(4'b0000, 4'b0011, 4'b0, 32'h0, 32'h0000_A1B2);
        chk("dual_vld", chk_vld, 4'b0011);
        chk("dual_pass", chk_pass, 4'b0011);
        cyc(4'b0, 4'b0, 4'b0, 32'h0, 32'h0);
        chk("dual_pulse_end", chk_vld, 4'b0000);

        // Second start on ch0 after PASS.
        cyc(4'b0001, 4'b0, 4'b0001, 32'h0000_0077, 32'h0);
`ifdef SB_REARM_EN
        chk("rearm_trk", tracking, 4'b0001);
        cyc(4'b0000, 4'b0001, 4'b0, 32'h0, 32'h0000_0077);
        chk("rearm_vld", chk_vld, 4'b0001);
        chk("rearm_pass", chk_pass, 4'b0001);
`else
        chk("norearm_trk", tracking, 4'b0000);
        cyc(4'b0000, 4'b0001, 4'b0, 32'h0, 32'h0000_0077);
        chk("norearm_vld", chk_vld, 4'b0000);
`endif

        // Asynchronous reset while ch1 tracks.
        do_reset();
        cyc(4'b0010, 4'b0, 4'b0010, 32'h0000_4400, 32'h0);
        chk("midrst_pre_trk", tracking, 4'b0010);
        @(negedge clk);
        rst = 1'b1; push = '0; start = '0;
        #1;
        chk("midrst_trk", tracking, 4'b0000);
        chk("midrst_vld", chk_vld, 4'b0000);
        chk("midrst_prop", prop_signal, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        cyc(4'b0010, 4'b0, 4'b0, 32'h0000_4400, 32'h0);
        cyc(4'b0000, 4'b0010, 4'b0, 32'h0, 32'h0000_4400);
        chk("midrst_post_vld", chk_vld, 4'b0000);
        chk("midrst_post_err", proto_err, 4'b0000);

        // Random traffic against the reference model.
        for (int n = 0; n < 1500; n++) begin
            if (n % 100 == 0) begin
                do_reset();
                model_reset();
            end
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                push[c]  = ($urandom_range(0, 1) == 1);
                pop[c]   = ($urandom_range(0, 2) != 0) && (mcnt[c] > 0 || $urandom_range(0, 9) == 0);
                start[c] = ($urandom_range(0, 7) == 0);
                flat_data_in[c*8 +: 8] = 8'($urandom);
                if (mcnt[c] > 0 && $urandom_range(0, 5) != 0)
                    flat_data_out[c*8 +: 8] = mdat[c][0];
                else
                    flat_data_out[c*8 +: 8] = 8'($urandom);
            end
            model_step();
            @(posedge clk);
            #1;
            chk("rnd_vld", chk_vld, exp_vld);
            chk("rnd_pass", chk_pass, exp_pass);
            chk("rnd_err", proto_err, merr);
            chk("rnd_trk", tracking, model_trk());
            chk("rnd_prop", prop_signal, model_prop());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
